// File: rtl/alu_9bit_arbiter_if.sv
// Request/response bus shared by the four ALU requesters and the result consumer.
interface alu_9bit_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_select;
    logic [9*NUM_REQ-1:0] req_a;
    logic [9*NUM_REQ-1:0] req_b;
    logic                 rsp_valid;
    logic [IW-1:0]        rsp_id;
    logic [8:0]           rsp_data;
    logic                 rsp_ready;

    // Requesters plus result consumer.
    modport master (
        output req_valid, req_select, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    // The arbitrated ALU.
    modport slave (
        input  req_valid, req_select, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_9bit_arbiter.sv
// Round-robin arbiter sharing one 9-bit ALU among four requesters, with a
// single result register drained by a valid/ready consumer.

module alu_9bit (
    input  logic [1:0] sel,
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] y
);
    // Sum/subtract wrap mod 512; min/max compare unsigned.
    always_comb begin
        y = '0;
        unique case (sel)
            2'b00: y = a + b;
            2'b01: y = a - b;
            2'b10: y = (a < b) ? a : b;
            2'b11: y = (a < b) ? b : a;
        endcase
    end
endmodule

module alu_9bit_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_9bit_arbiter_if.slave    bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] idx;
    logic          gnt_any;
    logic          slot_free;
    logic [1:0]    alu_sel;
    logic [8:0]    alu_a;
    logic [8:0]    alu_b;
    logic [8:0]    alu_y;

    // Slot frees when empty or drained this cycle; held low in reset.
    assign slot_free = !reset && (!bus.rsp_valid || bus.rsp_ready);

    // Round-robin search from ptr; first valid requester wins when the slot is free.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr + IW'(k);
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt_any = gnt_any && slot_free;
    end

    // One-hot accept for the winner only.
    always_comb begin
        bus.req_ready = '0;
        if (gnt_any)
            bus.req_ready[gnt_idx] = 1'b1;
    end

    // Route the winner's opcode and operands to the shared ALU.
    always_comb begin
        alu_sel = bus.req_select[gnt_idx*2 +: 2];
        alu_a   = bus.req_a[gnt_idx*9 +: 9];
        alu_b   = bus.req_b[gnt_idx*9 +: 9];
    end

    alu_9bit u_alu (
        .sel (alu_sel),
        .a   (alu_a),
        .b   (alu_b),
        .y   (alu_y)
    );

    // Result register and priority pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            ptr           <= '0;
        end else if (gnt_any) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= gnt_idx;
            bus.rsp_data  <= alu_y;
            ptr           <= gnt_idx + IW'(1);
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule
